// File: rtl/multi_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : multi_wb_scoreboard
// Purpose  : Issue scoreboard with per-register busy/tag tracking, per-FU busy
//            bits, RAW/WAW/structural stall detection and NWB writeback ports.
// Revision : 1.0 - initial release
// ============================================================================
module multi_wb_scoreboard #(
    parameter int NREGS = 32,
    parameter int NFU   = 4,
    parameter int NWB   = 2,
    localparam int RW   = $clog2(NREGS),
    localparam int FW   = $clog2(NFU)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RW-1:0]     in_rd,
    input  logic              in_wen,
    input  logic [RW-1:0]     in_rs1,
    input  logic [RW-1:0]     in_rs2,
    input  logic [FW-1:0]     in_fu,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [RW-1:0]     iss_rd,
    output logic [RW-1:0]     iss_rs1,
    output logic [RW-1:0]     iss_rs2,
    output logic              iss_wen,
    output logic [FW-1:0]     iss_fu,
    input  logic [NWB-1:0]    wb_valid,
    input  logic [NWB-1:0]    wb_wen,
    input  logic [NWB*RW-1:0] wb_rd,
    input  logic [NWB*FW-1:0] wb_fu,
    output logic [NREGS-1:0]  reg_busy,
    output logic [NFU-1:0]    fu_busy,
    output logic [2:0]        stall_src
);

    logic [NREGS-1:0] r_reg_busy;
    logic [FW-1:0]    r_tag [NREGS];
    logic [NFU-1:0]   r_fu_busy;
    logic             r_iss_valid;
    logic [RW-1:0]    r_iss_rd;
    logic [RW-1:0]    r_iss_rs1;
    logic [RW-1:0]    r_iss_rs2;
    logic             r_iss_wen;
    logic [FW-1:0]    r_iss_fu;

    logic [NREGS-1:0] w_eff_busy;
    logic [NFU-1:0]   w_eff_fu;
    logic             w_raw;
    logic             w_waw;
    logic             w_struct;
    logic             w_accept;

    // Effective state: every writeback of this cycle is applied before hazard
    // evaluation, so a dependent instruction can issue in the same cycle.
    always_comb begin
        w_eff_busy = r_reg_busy;
        w_eff_fu   = r_fu_busy;
        for (int k = 0; k < NWB; k++) begin
            if (wb_valid[k]) begin
                w_eff_fu[wb_fu[k*FW +: FW]] = 1'b0;
                if (wb_wen[k] && r_reg_busy[wb_rd[k*RW +: RW]] &&
                    (r_tag[wb_rd[k*RW +: RW]] == wb_fu[k*FW +: FW])) begin
                    w_eff_busy[wb_rd[k*RW +: RW]] = 1'b0;
                end
            end
        end
        w_eff_busy[0] = 1'b0;
    end

    assign w_raw    = w_eff_busy[in_rs1] | w_eff_busy[in_rs2];
    assign w_waw    = in_wen && w_eff_busy[in_rd];
    assign w_struct = w_eff_fu[in_fu];

    assign in_ready = !RST && !flush && !freeze && !w_raw && !w_waw && !w_struct &&
                      (!r_iss_valid || iss_ready);
    assign w_accept = in_valid && in_ready;

    assign stall_src = (in_valid && !RST) ? {w_struct, w_waw, w_raw} : 3'b000;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_reg_busy  <= '0;
            r_fu_busy   <= '0;
            r_iss_valid <= 1'b0;
            r_iss_rd    <= '0;
            r_iss_rs1   <= '0;
            r_iss_rs2   <= '0;
            r_iss_wen   <= 1'b0;
            r_iss_fu    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_reg_busy <= w_eff_busy;
            r_fu_busy  <= w_eff_fu;
            // Later NBAs win, so an accept overrides a same-cycle clear.
            if (w_accept) begin
                r_fu_busy[in_fu] <= 1'b1;
                if (in_wen && (in_rd != '0)) begin
                    r_reg_busy[in_rd] <= 1'b1;
                    r_tag[in_rd]      <= in_fu;
                end
                r_iss_valid <= 1'b1;
                r_iss_rd    <= in_rd;
                r_iss_rs1   <= in_rs1;
                r_iss_rs2   <= in_rs2;
                r_iss_wen   <= in_wen;
                r_iss_fu    <= in_fu;
            end else if (r_iss_valid && iss_ready) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    assign iss_valid = r_iss_valid;
    assign iss_rd    = r_iss_rd;
    assign iss_rs1   = r_iss_rs1;
    assign iss_rs2   = r_iss_rs2;
    assign iss_wen   = r_iss_wen;
    assign iss_fu    = r_iss_fu;
    assign reg_busy  = r_reg_busy;
    assign fu_busy   = r_fu_busy;

endmodule
`default_nettype wire

// File: tb/tb_multi_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_wb_scoreboard
// Purpose  : Directed self-checking bench for multi_wb_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_wb_scoreboard;

    localparam int NREGS = 32;
    localparam int NFU   = 4;
    localparam int NWB   = 2;
    localparam int RW    = 5;
    localparam int FW    = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              flush;
    logic              freeze;
    logic              in_valid;
    logic              in_ready;
    logic [RW-1:0]     in_rd;
    logic              in_wen;
    logic [RW-1:0]     in_rs1;
    logic [RW-1:0]     in_rs2;
    logic [FW-1:0]     in_fu;
    logic              iss_valid;
    logic              iss_ready;
    logic [RW-1:0]     iss_rd;
    logic [RW-1:0]     iss_rs1;
    logic [RW-1:0]     iss_rs2;
    logic              iss_wen;
    logic [FW-1:0]     iss_fu;
    logic [NWB-1:0]    wb_valid;
    logic [NWB-1:0]    wb_wen;
    logic [NWB*RW-1:0] wb_rd;
    logic [NWB*FW-1:0] wb_fu;
    logic [NREGS-1:0]  reg_busy;
    logic [NFU-1:0]    fu_busy;
    logic [2:0]        stall_src;

    int n_tests = 0;
    int n_fail  = 0;

    multi_wb_scoreboard #(.NREGS(NREGS), .NFU(NFU), .NWB(NWB)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_fu(in_fu),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_wen(iss_wen), .iss_fu(iss_fu),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_fu(wb_fu),
        .reg_busy(reg_busy), .fu_busy(fu_busy), .stall_src(stall_src)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input int rd, input int rs1, input int rs2, input bit wen, input int fu);
        in_valid = 1'b1;
        in_rd    = RW'(rd);
        in_rs1   = RW'(rs1);
        in_rs2   = RW'(rs2);
        in_wen   = wen;
        in_fu    = FW'(fu);
    endtask

    task automatic wb(input int port, input int rd, input int fu, input bit wen);
        wb_valid[port]          = 1'b1;
        wb_wen[port]            = wen;
        wb_rd[port*RW +: RW]    = RW'(rd);
        wb_fu[port*FW +: FW]    = FW'(fu);
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_wen   = '0;
        wb_rd    = '0;
        wb_fu    = '0;
    endtask

    initial begin
        RST = 1'b1; flush = 1'b0; freeze = 1'b0; iss_ready = 1'b1;
        wb_clear();
        issue(5, 0, 0, 1'b1, 1);

        // reset with an instruction offered
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_reg_busy", reg_busy, 0);
        check("rst_fu_busy", fu_busy, 0);
        check("rst_stall", stall_src, 0);
        check("rst_iss_rd", iss_rd, 0);
        RST = 1'b0; in_valid = 1'b0;
        step();

        // RAW stall then same-cycle wakeup
        issue(5, 0, 0, 1'b1, 1);
        #1 check("raw_first_ready", in_ready, 1);
        step();
        issue(6, 5, 0, 1'b1, 2);
        #1;
        check("raw_iss_valid", iss_valid, 1);
        check("raw_iss_rd", iss_rd, 5);
        check("raw_busy", reg_busy, 32'h0000_0020);
        check("raw_fu_busy", fu_busy, 4'b0010);
        check("raw_stall", stall_src, 3'b001);
        check("raw_ready_low", in_ready, 0);
        wb(0, 5, 1, 1'b1);
        #1;
        check("raw_wb_ready", in_ready, 1);
        check("raw_wb_stall", stall_src, 3'b000);
        step();
        wb_clear(); in_valid = 1'b0;
        check("raw_acc_valid", iss_valid, 1);
        check("raw_acc_rs1", iss_rs1, 5);
        check("raw_acc_rd", iss_rd, 6);
        check("raw_acc_busy", reg_busy, 32'h0000_0040);
        check("raw_acc_fu", fu_busy, 4'b0100);
        wb(0, 6, 2, 1'b1);
        step();
        wb_clear();
        check("raw_drain_valid", iss_valid, 0);
        check("raw_drain_busy", reg_busy, 0);
        check("raw_drain_fu", fu_busy, 0);

        // dual writeback and tag mismatch
        issue(3, 0, 0, 1'b1, 0); step();
        issue(7, 0, 0, 1'b1, 2); step();
        in_valid = 1'b0;
        check("dual_busy", reg_busy, 32'h0000_0088);
        check("dual_fu", fu_busy, 4'b0101);
        wb(0, 3, 1, 1'b1);
        step();
        wb_clear();
        check("dual_wrong_tag", reg_busy, 32'h0000_0088);
        wb(0, 3, 0, 1'b1);
        wb(1, 7, 2, 1'b1);
        step();
        wb_clear();
        check("dual_clear_busy", reg_busy, 0);
        check("dual_clear_fu", fu_busy, 0);

        // WAW with accept/writeback collision on the same register
        issue(9, 0, 0, 1'b1, 0); step();
        issue(9, 0, 0, 1'b1, 3);
        #1;
        check("waw_stall", stall_src, 3'b010);
        check("waw_ready_low", in_ready, 0);
        wb(0, 9, 0, 1'b1);
        #1 check("waw_wb_ready", in_ready, 1);
        step();
        wb_clear(); in_valid = 1'b0;
        check("waw_busy", reg_busy, 32'h0000_0200);
        check("waw_fu", fu_busy, 4'b1000);
        check("waw_iss_fu", iss_fu, 3);
        wb(0, 9, 0, 1'b1);
        step();
        wb_clear();
        check("waw_old_tag", reg_busy, 32'h0000_0200);
        wb(0, 9, 3, 1'b1);
        step();
        wb_clear();
        check("waw_new_tag", reg_busy, 0);
        check("waw_fu_clear", fu_busy, 0);

        // backpressure holds the issue register
        iss_ready = 1'b0;
        issue(10, 0, 0, 1'b1, 1); step();
        issue(11, 4, 0, 1'b1, 2);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_ready_low", in_ready, 0);
            check("bp_iss_rd", iss_rd, 10);
            check("bp_iss_valid", iss_valid, 1);
            step();
        end
        iss_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_b2b_valid", iss_valid, 1);
        check("bp_b2b_rd", iss_rd, 11);
        check("bp_b2b_rs1", iss_rs1, 4);
        step();
        check("bp_drain", iss_valid, 0);
        wb(0, 10, 1, 1'b1);
        wb(1, 11, 2, 1'b1);
        step();
        wb_clear();
        check("bp_clear", reg_busy, 0);

        // flush mid-operation, then freeze
        issue(1, 0, 0, 1'b1, 0); step();
        issue(2, 0, 0, 1'b1, 1);
        wb(0, 0, 0, 1'b0);
        step();
        wb_clear();
        issue(3, 0, 0, 1'b1, 0); step();
        iss_ready = 1'b0;
        issue(20, 0, 0, 1'b1, 3);
        flush = 1'b1;
        wb(0, 1, 0, 1'b1);
        #1;
        check("fl_pre_busy", reg_busy, 32'h0000_000E);
        check("fl_pre_fu", fu_busy, 4'b0011);
        check("fl_pre_valid", iss_valid, 1);
        check("fl_ready_low", in_ready, 0);
        step();
        flush = 1'b0; wb_clear(); in_valid = 1'b0; iss_ready = 1'b1;
        check("fl_valid", iss_valid, 0);
        check("fl_busy", reg_busy, 0);
        check("fl_fu", fu_busy, 0);
        check("fl_iss_rd", iss_rd, 0);
        issue(4, 0, 0, 1'b1, 2); step();
        freeze = 1'b1;
        issue(21, 0, 0, 1'b1, 3);
        wb(0, 4, 2, 1'b1);
        #1 check("frz_ready_low", in_ready, 0);
        step();
        wb_clear();
        check("frz_wb_busy", reg_busy, 0);
        check("frz_wb_fu", fu_busy, 0);
        check("frz_iss_valid", iss_valid, 0);
        freeze = 1'b0;
        #1 check("frz_release", in_ready, 1);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
